// File: rtl/spi_burst_ctrl.sv
// Multi-byte SPI burst sequencer: frames CS around N engine byte transfers.
// Optional wr_ack watchdog is enabled by defining SPI_BURST_ACK_TIMEOUT_EN.
module spi_burst_ctrl #(
  parameter int CS_SETUP    = 4,
  parameter int CS_HOLD     = 4,
  parameter int BYTE_GAP    = 2,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [7:0] len,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       spi_cs_ctrl,
  output logic       spi_wr_req,
  input  logic       spi_wr_ack,
  output logic [7:0] spi_data_tx,
  input  logic [7:0] spi_data_rx
);

`ifdef SPI_BURST_ACK_TIMEOUT_EN
  localparam bit ACK_TO_EN = 1'b1;
`else
  localparam bit ACK_TO_EN = 1'b0;
`endif

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(BYTE_GAP - 1);
  localparam logic [15:0] TO_LAST    = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, XFER, GAP, HOLD} state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       tx_ready;
    logic       rx_valid;
    logic       cs;
    logic       wr_req;
    logic [7:0] rx_data;
    logic [7:0] data_tx;
  } out_t;

  state_t      state, state_d;
  out_t        q, d;
  logic [7:0]  byte_cnt, byte_cnt_d;
  logic [15:0] dly, dly_d;
  logic [15:0] wd, wd_d;
  logic        abort_q, abort_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      q        <= '0;
      q.cs     <= 1'b1;
      byte_cnt <= '0;
      dly      <= '0;
      wd       <= '0;
      abort_q  <= 1'b0;
    end else begin
      state    <= state_d;
      q        <= d;
      byte_cnt <= byte_cnt_d;
      dly      <= dly_d;
      wd       <= wd_d;
      abort_q  <= abort_d;
    end
  end

  // tx_ready is issued one cycle ahead of the LOAD decision so that it is
  // visible in the LOAD cycle itself; the byte is taken on the edge after it.
  always_comb begin
    state_d    = state;
    d          = q;
    d.done     = 1'b0;
    d.err      = 1'b0;
    d.tx_ready = 1'b0;
    d.rx_valid = 1'b0;
    byte_cnt_d = byte_cnt;
    dly_d      = dly;
    wd_d       = wd;
    abort_d    = abort_q | abort;
    unique case (state)
      IDLE: begin
        abort_d = 1'b0;
        dly_d   = '0;
        if (start && len != 8'd0) begin
          state_d    = SETUP;
          byte_cnt_d = len;
          d.busy     = 1'b1;
          d.cs       = 1'b0;
        end
      end
      SETUP: begin
        if (abort_d) begin
          state_d = HOLD;
          dly_d   = '0;
        end else if (dly == SETUP_LAST) begin
          state_d    = LOAD;
          dly_d      = '0;
          d.tx_ready = tx_valid;
        end else begin
          dly_d = dly + 16'd1;
        end
      end
      LOAD: begin
        if (abort_d) begin
          state_d = HOLD;
          dly_d   = '0;
        end else if (q.tx_ready) begin
          state_d   = XFER;
          d.data_tx = tx_data;
          d.wr_req  = 1'b1;
          wd_d      = '0;
        end else begin
          d.tx_ready = tx_valid;
        end
      end
      XFER: begin
        if (spi_wr_ack) begin
          d.wr_req   = 1'b0;
          d.rx_data  = spi_data_rx;
          d.rx_valid = 1'b1;
          byte_cnt_d = byte_cnt - 8'd1;
          dly_d      = '0;
          state_d    = (byte_cnt == 8'd1 || abort_d) ? HOLD : GAP;
        end else if (ACK_TO_EN && wd == TO_LAST) begin
          d.wr_req = 1'b0;
          d.err    = 1'b1;
          dly_d    = '0;
          state_d  = HOLD;
        end else begin
          wd_d = wd + 16'd1;
        end
      end
      GAP: begin
        if (abort_d) begin
          state_d = HOLD;
          dly_d   = '0;
        end else if (dly == GAP_LAST) begin
          state_d    = LOAD;
          dly_d      = '0;
          d.tx_ready = tx_valid;
        end else begin
          dly_d = dly + 16'd1;
        end
      end
      HOLD: begin
        if (dly == HOLD_LAST) begin
          state_d = IDLE;
          dly_d   = '0;
          d.cs    = 1'b1;
          d.done  = 1'b1;
          d.busy  = 1'b0;
        end else begin
          dly_d = dly + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = q.busy;
  assign done        = q.done;
  assign err         = q.err;
  assign tx_ready    = q.tx_ready;
  assign rx_valid    = q.rx_valid;
  assign rx_data     = q.rx_data;
  assign spi_cs_ctrl = q.cs;
  assign spi_wr_req  = q.wr_req;
  assign spi_data_tx = q.data_tx;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: timeline model of expected outputs per cycle plus literal timing checks.
module tb_spi_burst_ctrl;
  localparam int CS_SETUP = 4, CS_HOLD = 4, BYTE_GAP = 2, ACK_TO = 100, NC = 4096;

  logic       sys_clk = 1'b0, sys_rst_n = 1'b1;
  logic       start = 1'b0, abort = 1'b0, tx_valid = 1'b0, spi_wr_ack = 1'b0;
  logic [7:0] len = '0, tx_data = '0, spi_data_rx = '0;
  logic       busy, done, err, tx_ready, rx_valid, spi_cs_ctrl, spi_wr_req;
  logic [7:0] rx_data, spi_data_tx;

  spi_burst_ctrl #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .BYTE_GAP(BYTE_GAP),
                   .ACK_TIMEOUT(ACK_TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .len(len), .abort(abort),
    .busy(busy), .done(done), .err(err), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .spi_cs_ctrl(spi_cs_ctrl),
    .spi_wr_req(spi_wr_req), .spi_wr_ack(spi_wr_ack), .spi_data_tx(spi_data_tx),
    .spi_data_rx(spi_data_rx));

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  bit run_chk = 1'b1;

  // expected waveform, indexed by cycle
  logic       e_cs[NC], e_busy[NC], e_done[NC], e_err[NC], e_txr[NC], e_wr[NC], e_rxv[NC];
  logic [7:0] e_dtx[NC], e_rxd[NC];
  int abort_at = 0, plan_end = 0;

  // stimulus-side state shared with the feeder and engine processes
  logic [7:0] tx_bytes[8];
  int  tx_idx = 0;
  bit  acc = 1'b0;
  bit  echo = 1'b1, eng_en = 1'b1;
  int  eng_lat = 40, eng_cnt = 0;

  // monitor
  int cs_fall, cs_rise, txr_cyc, err_cyc, done_cyc, ndone, ntxr;
  int wr_rises[$], acks[$];
  logic [7:0] rxq[$];
  logic prev_cs = 1'b1, prev_wr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_mon();
    cs_fall = -1; cs_rise = -1; txr_cyc = -1; err_cyc = -1; done_cyc = -1;
    ndone = 0; ntxr = 0;
    wr_rises.delete(); acks.delete(); rxq.delete();
  endtask

  task automatic go_cyc(input int c);
    while (cyc < c) begin
      @(posedge sys_clk); #1;
    end
  endtask

  // Burst timeline from the protocol rules: setup, load, ack latency, gap, hold.
  task automatic plan(input int t, input int n, input int lat, input int vdly,
                      input int abort_byte, input bit to);
    int r, w, a, fin;
    r = (vdly == 0) ? t + 1 + CS_SETUP : t + 1 + CS_SETUP + vdly + 1;
    a = 0;
    for (int i = 0; i < n; i++) begin
      e_txr[r] = 1'b1;
      w = r + 1;
      if (to) begin
        a = w + ACK_TO - 1;
        for (int c = w; c <= a; c++) begin e_wr[c] = 1'b1; e_dtx[c] = tx_bytes[i]; end
        e_err[a + 1] = 1'b1;
        break;
      end
      a = w + lat;
      for (int c = w; c <= a; c++) begin e_wr[c] = 1'b1; e_dtx[c] = tx_bytes[i]; end
      e_rxv[a + 1] = 1'b1;
      e_rxd[a + 1] = echo ? tx_bytes[i] : ~tx_bytes[i];
      if (i == abort_byte) abort_at = w + 3;
      if (i == n - 1 || i == abort_byte) break;
      r = a + 1 + BYTE_GAP;
    end
    fin = a + 1 + CS_HOLD;
    for (int c = t + 1; c < fin; c++) begin e_cs[c] = 1'b0; e_busy[c] = 1'b1; end
    e_done[fin] = 1'b1;
    plan_end = fin;
  endtask

  // TX requester: advances to the next byte after each accepted handshake
  initial forever begin
    @(posedge sys_clk); #1;
    if (acc) tx_idx++;
    acc = tx_ready && tx_valid;
    tx_data = tx_bytes[tx_idx % 8];
  end

  // byte engine: acks eng_lat cycles after wr_req first seen
  initial forever begin
    @(posedge sys_clk); #1;
    spi_wr_ack  = 1'b0;
    spi_data_rx = 8'h11;
    if (!sys_rst_n) eng_cnt = 0;
    else if (spi_wr_req && eng_en) begin
      if (eng_cnt == eng_lat) begin
        spi_wr_ack  = 1'b1;
        spi_data_rx = echo ? spi_data_tx : ~spi_data_tx;
        eng_cnt     = 0;
      end else eng_cnt++;
    end
  end

  // compare + monitor
  initial forever begin
    @(negedge sys_clk);
    if (run_chk && cyc < NC) begin
      chk("cs", spi_cs_ctrl, e_cs[cyc]);
      chk("busy", busy, e_busy[cyc]);
      chk("done", done, e_done[cyc]);
      chk("err", err, e_err[cyc]);
      chk("tx_ready", tx_ready, e_txr[cyc]);
      chk("wr_req", spi_wr_req, e_wr[cyc]);
      chk("rx_valid", rx_valid, e_rxv[cyc]);
      if (e_wr[cyc]) chk("data_tx", spi_data_tx, e_dtx[cyc]);
      if (e_rxv[cyc]) chk("rx_data", rx_data, e_rxd[cyc]);
    end
    if (prev_cs && !spi_cs_ctrl) cs_fall = cyc;
    if (!prev_cs && spi_cs_ctrl) cs_rise = cyc;
    if (!prev_wr && spi_wr_req) wr_rises.push_back(cyc);
    if (spi_wr_ack) acks.push_back(cyc);
    if (rx_valid) rxq.push_back(rx_data);
    if (tx_ready) begin ntxr++; txr_cyc = cyc; end
    if (done) begin ndone++; done_cyc = cyc; end
    if (err) err_cyc = cyc;
    prev_cs = spi_cs_ctrl;
    prev_wr = spi_wr_req;
  end

  initial begin
    int t;
    for (int c = 0; c < NC; c++) begin
      e_cs[c] = 1'b1; e_busy[c] = 1'b0; e_done[c] = 1'b0; e_err[c] = 1'b0;
      e_txr[c] = 1'b0; e_wr[c] = 1'b0; e_rxv[c] = 1'b0; e_dtx[c] = '0; e_rxd[c] = '0;
    end
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'h00;
    clear_mon();
    #1 sys_rst_n = 1'b0;
    go_cyc(2);
    chk("rst_cs", spi_cs_ctrl, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_req", spi_wr_req, 0);
    chk("rst_tx_ready", tx_ready, 0);
    go_cyc(3);
    sys_rst_n = 1'b1;

    // 1: three bytes, always valid, 40-cycle echo engine; start while busy ignored
    go_cyc(6);
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h5A; tx_bytes[2] = 8'hFF;
    tx_idx = 0; tx_valid = 1'b1; echo = 1'b1; eng_lat = 40; eng_en = 1'b1;
    go_cyc(8);
    clear_mon();
    t = cyc;
    plan(t, 3, 40, 0, -1, 1'b0);
    start = 1'b1; len = 8'd3;
    go_cyc(t + 1); start = 1'b0;
    go_cyc(t + 30); start = 1'b1; len = 8'd7;
    go_cyc(t + 31); start = 1'b0;
    go_cyc(plan_end + 3);
    chk("t1_rx_count", rxq.size(), 3);
    chk("t1_done_count", ndone, 1);
    if (rxq.size() == 3) begin
      chk("t1_rx0", rxq[0], 8'hA5);
      chk("t1_rx1", rxq[1], 8'h5A);
      chk("t1_rx2", rxq[2], 8'hFF);
    end
    if (wr_rises.size() == 3 && acks.size() == 3) begin
      chk("t1_setup_to_wr", wr_rises[0] - cs_fall, 5);
      chk("t1_ack_to_wr", wr_rises[1] - acks[0], 4);
      chk("t1_ack_to_cs", cs_rise - acks[2], 5);
      chk("t1_done_at_cs", done_cyc, cs_rise);
    end else chk("t1_wr_ack_count", wr_rises.size() * 10 + acks.size(), 33);

    // 2: one byte, tx_valid stalled 20 cycles into LOAD
    tx_valid = 1'b0; tx_bytes[0] = 8'h3C; tx_idx = 0; echo = 1'b0; eng_lat = 6;
    go_cyc(cyc + 2);
    clear_mon();
    t = cyc;
    plan(t, 1, 6, 20, -1, 1'b0);
    start = 1'b1; len = 8'd1;
    go_cyc(t + 1); start = 1'b0;
    go_cyc(t + 1 + CS_SETUP + 20); tx_valid = 1'b1;
    go_cyc(plan_end + 3);
    if (wr_rises.size() == 1) begin
      chk("t2_cs_to_wr", wr_rises[0] - cs_fall, 26);
      chk("t2_ready_to_wr", wr_rises[0] - txr_cyc, 1);
    end else chk("t2_wr_count", wr_rises.size(), 1);
    if (rxq.size() == 1) chk("t2_rx0", rxq[0], 8'hC3);
    else chk("t2_rx_count", rxq.size(), 1);

    // 3: len=4, abort during second byte transfer
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33; tx_bytes[3] = 8'h44;
    tx_idx = 0; eng_lat = 10;
    go_cyc(cyc + 2);
    clear_mon();
    t = cyc;
    plan(t, 4, 10, 0, 1, 1'b0);
    start = 1'b1; len = 8'd4;
    go_cyc(t + 1); start = 1'b0;
    go_cyc(abort_at); abort = 1'b1;
    go_cyc(abort_at + 1); abort = 1'b0;
    go_cyc(plan_end + 3);
    chk("t3_tx_ready_count", ntxr, 2);
    chk("t3_done_count", ndone, 1);
    if (rxq.size() == 2) chk("t3_rx1", rxq[1], 8'hDD);
    else chk("t3_rx_count", rxq.size(), 2);

    // 4: len=0 start is ignored
    clear_mon();
    start = 1'b1; len = 8'd0;
    go_cyc(cyc + 1); start = 1'b0;
    go_cyc(cyc + 10);
    chk("t4_done_count", ndone, 0);
    chk("t4_wr_count", wr_rises.size(), 0);
    chk("t4_cs_fall", cs_fall, -1);

`ifdef SPI_BURST_ACK_TIMEOUT_EN
    // 5: engine never acks; watchdog fires
    tx_idx = 0; eng_en = 1'b0;
    go_cyc(cyc + 2);
    clear_mon();
    t = cyc;
    plan(t, 2, 0, 0, -1, 1'b1);
    start = 1'b1; len = 8'd2;
    go_cyc(t + 1); start = 1'b0;
    go_cyc(plan_end + 3);
    eng_en = 1'b1;
    if (wr_rises.size() == 1) chk("t5_wr_to_err", err_cyc - wr_rises[0], 100);
    else chk("t5_wr_count", wr_rises.size(), 1);
    chk("t5_err_to_done", done_cyc - err_cyc, 4);
    chk("t5_rx_count", rxq.size(), 0);
`endif

    // 6: asynchronous reset mid-transfer
    tx_idx = 0; eng_lat = 10;
    go_cyc(cyc + 2);
    t = cyc;
    plan(t, 2, 10, 0, -1, 1'b0);
    start = 1'b1; len = 8'd2;
    go_cyc(t + 1); start = 1'b0;
    go_cyc(t + 1 + CS_SETUP + 1 + 3);
    chk("t6_pre_cs", spi_cs_ctrl, 0);
    run_chk = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_cs", spi_cs_ctrl, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wr_req", spi_wr_req, 0);
    chk("t6_rst_rx_valid", rx_valid, 0);
    chk("t6_rst_done", done, 0);
    go_cyc(cyc + 3);
    sys_rst_n = 1'b1;
    go_cyc(cyc + 3);
    chk("t6_post_cs", spi_cs_ctrl, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit reached at cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
